booth_r4_seq_mult: RTL

//  Sequential radix-4 Booth multiplier for the FIR tap datapath. Consumes one signed

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_r4_enc.sv | 40 ++++
 rtl/booth_r4_seq_mult.sv | 132 +++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
//  - DEFAULT_WIDTH : default operand width
//  - state_t       : controller states (IDLE / RUN / DONE)
//  - sel_t         : partial-product magnitude select (ZERO / ONE / TWO)
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_TWO  = 2'd2
  } sel_t;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit encoder (purely combinational).
// Ports:
//  window  in  3  multiplier bits {y[2i+1], y[2i], y[2i-1]}
//  neg     out 1  digit is negative
//  sel_2x  out 1  digit magnitude is 2
//  zero    out 1  digit is zero
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       sel_2x,
  output logic       zero
);

  sel_t sel_s;
  logic neg_s;

  // Map the 3-bit window to the digit d = -2*w[2] + w[1] + w[0].
  always_comb begin
    sel_s = SEL_ZERO;
    neg_s = 1'b0;
    case (window)
      3'b000: begin sel_s = SEL_ZERO; neg_s = 1'b0; end
      3'b001: begin sel_s = SEL_ONE;  neg_s = 1'b0; end
      3'b010: begin sel_s = SEL_ONE;  neg_s = 1'b0; end
      3'b011: begin sel_s = SEL_TWO;  neg_s = 1'b0; end
      3'b100: begin sel_s = SEL_TWO;  neg_s = 1'b1; end
      3'b101: begin sel_s = SEL_ONE;  neg_s = 1'b1; end
      3'b110: begin sel_s = SEL_ONE;  neg_s = 1'b1; end
      // 3'b111 is d = 0; treat as a plain zero (no negation needed).
      default: begin sel_s = SEL_ZERO; neg_s = 1'b0; end
    endcase
  end

  assign neg    = neg_s;
  assign sel_2x = (sel_s == SEL_TWO);
  assign zero   = (sel_s == SEL_ZERO);

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one signed operand pair in, one signed
// product out, two multiplier bits retired per RUN cycle.
// Ports:
//  clk           in  1        rising-edge clock
//  rst           in  1        synchronous active-high reset
//  in_valid      in  1        operand pair valid
//  in_ready      out 1        accepting operands (controller idle)
//  multiplicand  in  WIDTH    signed x
//  multiplier    in  WIDTH    signed y
//  out_valid     out 1        product valid, held until out_ready
//  out_ready     in  1        downstream accepts product
//  product       out 2*WIDTH  signed x*y, registered
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH / 2 - 1);
  localparam logic [PW-1:0]    PP_ONE     = {{(PW-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;      // shifts right two bits per digit
  logic             y_prev_r; // y[2i-1] for the current digit
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    acc_r;

  logic             neg_s;
  logic             sel_2x_s;
  logic             zero_s;
  logic [WIDTH:0]   pp9_s;
  logic [PW-1:0]    pp_ext_s;
  logic [PW-1:0]    pp_signed_s;
  logic [PW-1:0]    acc_next_s;

  assign in_ready = (state_r == ST_IDLE);

  booth_r4_enc u_enc (
    .window (({y_r[1:0], y_prev_r})),
    .neg    (neg_s),
    .sel_2x (sel_2x_s),
    .zero   (zero_s)
  );

  // Form the signed partial product for the current digit and the next accumulator.
  always_comb begin
    pp9_s = '0;
    if (zero_s) begin
      pp9_s = '0;
    end else if (sel_2x_s) begin
      // 9-bit 2x is exact even for x = -2^(W-1).
      pp9_s = {x_r, 1'b0};
    end else begin
      pp9_s = {x_r[WIDTH-1], x_r};
    end
    pp_ext_s = {{(PW-WIDTH-1){pp9_s[WIDTH]}}, pp9_s};
    if (neg_s) begin
      pp_signed_s = ~pp_ext_s + PP_ONE;
    end else begin
      pp_signed_s = pp_ext_s;
    end
    acc_next_s = acc_r + (pp_signed_s << {cnt_r, 1'b0});
  end

  // Controller, operand registers, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      x_r       <= '0;
      y_r       <= '0;
      y_prev_r  <= 1'b0;
      cnt_r     <= '0;
      acc_r     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r      <= multiplicand;
            y_r      <= multiplier;
            y_prev_r <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            state_r  <= ST_RUN;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r    <= acc_next_s;
          y_r      <= y_r >> 2;
          y_prev_r <= y_r[1];
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_DIGIT) begin
            product   <= acc_next_s;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
